mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one RAM port between an instruction cache (reads) and a data cache
// (reads/writes). Data requests win unless the icache has been starved STARVE_MAX times.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_IGRANT = 2'd1;
  localparam logic [1:0] S_DGRANT = 2'd2;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic [2:0] r_starve_cnt;
  logic       r_err;
  logic       r_rst_done;

  logic w_dreq;
  logic w_igrant_live;
  logic w_dgrant_live;
  logic w_i_done;
  logic w_d_done;
  logic w_ram_err;

  assign w_dreq        = dREN | dWEN;
  assign w_igrant_live = (r_state == S_IGRANT) && iREN;
  assign w_dgrant_live = (r_state == S_DGRANT) && w_dreq;
  assign w_i_done      = w_igrant_live && (ramstate == RAM_ACCESS);
  assign w_d_done      = w_dgrant_live && (ramstate == RAM_ACCESS);
  assign w_ram_err     = (w_igrant_live || w_dgrant_live) && (ramstate == RAM_ERROR);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // r_rst_done holds off any grant until the second edge after reset release.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_starve_cnt <= 3'd0;
      r_err        <= 1'b0;
      r_rst_done   <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
      if (w_ram_err) begin
        r_err <= 1'b1;
      end
      if (!iREN || w_i_done) begin
        r_starve_cnt <= 3'd0;
      end else if (w_d_done && (r_starve_cnt != 3'd7)) begin
        r_starve_cnt <= r_starve_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (!r_rst_done) begin
          w_next_state = S_IDLE;
        end else if (w_dreq && (r_starve_cnt < STARVE_LIM)) begin
          w_next_state = S_DGRANT;
        end else if (iREN) begin
          w_next_state = S_IGRANT;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_IGRANT: begin
        if (!iREN || w_i_done) begin
          w_next_state = S_IDLE;
        end
      end
      S_DGRANT: begin
        if (!w_dreq || w_d_done) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // A withdrawn request drops the RAM strobes in the same cycle.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (r_state)
      S_IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iwait   = !w_i_done;
      end
      S_DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN && !dWEN;
        dwait    = !w_d_done;
      end
      default: ;
    endcase
  end

  assign iload = ramload;
  assign dload = ramload;
  assign err   = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed checks of mem_arbiter: reset, reads, writes, priority, starvation,
// abort and error handling.
module tb_mem_arbiter;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err;

  int n_total;
  int n_bad;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .err      (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed and outputs
  // sampled 1 time unit later, well away from either clock edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_total  = 0;
    n_bad    = 0;
    nRST     = 1'b0;
    iREN     = 1'b0;
    iaddr    = 32'd0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = 32'd0;
    dstore   = 32'd0;
    ramload  = 32'd0;
    ramstate = FREE;

    // Reset values
    #2;
    chk("rst_iwait", 32'(iwait), 32'd1);
    chk("rst_dwait", 32'(dwait), 32'd1);
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    cyc();
    cyc();

    // Grant held off until the second edge after reset release
    nRST     = 1'b1;
    dREN     = 1'b1;
    daddr    = 32'h200;
    ramstate = BUSY;
    #1;
    chk("rel_idle_ren", 32'(ramREN), 32'd0);
    cyc();
    chk("rel_edge1_ren", 32'(ramREN), 32'd0);
    chk("rel_edge1_dwait", 32'(dwait), 32'd1);
    cyc();
    chk("rel_edge2_ren", 32'(ramREN), 32'd1);
    chk("rel_edge2_addr", ramaddr, 32'h200);
    ramstate = ACCESS;
    ramload  = 32'h0000_1234;
    #1;
    chk("rel_dwait", 32'(dwait), 32'd0);
    chk("rel_dload", dload, 32'h0000_1234);
    cyc();
    dREN     = 1'b0;
    ramstate = FREE;
    #1;
    chk("rel_back_idle", 32'(ramREN), 32'd0);
    $display("txn reset_release done");

    // Instruction read with two BUSY cycles
    iREN  = 1'b1;
    iaddr = 32'h40;
    #1;
    chk("ird_idle_iwait", 32'(iwait), 32'd1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      ramstate = (k == 2) ? ACCESS : BUSY;
      ramload  = (k == 2) ? 32'h8C22_0004 : 32'h0;
      #1;
      chk("ird_ren", 32'(ramREN), 32'd1);
      chk("ird_addr", ramaddr, 32'h40);
      chk("ird_iwait", 32'(iwait), (k == 2) ? 32'd0 : 32'd1);
      chk("ird_dwait", 32'(dwait), 32'd1);
    end
    chk("ird_iload", iload, 32'h8C22_0004);
    cyc();
    iREN     = 1'b0;
    ramstate = FREE;
    #1;
    chk("ird_idle_after", 32'(dut.r_state), 32'd0);
    chk("ird_iwait_after", 32'(iwait), 32'd1);
    $display("txn icache_read done");

    // Simultaneous requests: data first, an IDLE cycle, then instruction
    iREN  = 1'b1;
    dREN  = 1'b1;
    iaddr = 32'h44;
    daddr = 32'h80;
    cyc();
    ramstate = ACCESS;
    ramload  = 32'h55;
    #1;
    chk("sim_d_addr", ramaddr, 32'h80);
    chk("sim_d_dwait", 32'(dwait), 32'd0);
    chk("sim_d_iwait", 32'(iwait), 32'd1);
    cyc();
    dREN     = 1'b0;
    ramstate = FREE;
    #1;
    chk("sim_gap_ren", 32'(ramREN), 32'd0);
    chk("sim_starve1", 32'(dut.r_starve_cnt), 32'd1);
    cyc();
    ramstate = ACCESS;
    #1;
    chk("sim_i_addr", ramaddr, 32'h44);
    chk("sim_i_iwait", 32'(iwait), 32'd0);
    chk("sim_i_dwait", 32'(dwait), 32'd1);
    cyc();
    iREN     = 1'b0;
    ramstate = FREE;
    #1;
    chk("sim_starve0", 32'(dut.r_starve_cnt), 32'd0);
    $display("txn simultaneous done");

    // Write: dWEN wins over dREN
    dREN     = 1'b1;
    dWEN     = 1'b1;
    daddr    = 32'h100;
    dstore   = 32'hDEAD_BEEF;
    ramstate = BUSY;
    #1;
    chk("wr_idle_store", ramstore, 32'd0);
    chk("wr_idle_wen", 32'(ramWEN), 32'd0);
    cyc();
    chk("wr_wen", 32'(ramWEN), 32'd1);
    chk("wr_ren", 32'(ramREN), 32'd0);
    chk("wr_store", ramstore, 32'hDEAD_BEEF);
    chk("wr_addr", ramaddr, 32'h100);
    chk("wr_busy_dwait", 32'(dwait), 32'd1);
    ramstate = ACCESS;
    #1;
    chk("wr_dwait", 32'(dwait), 32'd0);
    cyc();
    dREN     = 1'b0;
    dWEN     = 1'b0;
    ramstate = FREE;
    #1;
    chk("wr_idle_after", 32'(dut.r_state), 32'd0);
    $display("txn dcache_write done");

    // Starvation: four data grants, then the instruction grant
    iREN  = 1'b1;
    iaddr = 32'h300;
    dREN  = 1'b1;
    daddr = 32'h700;
    for (int k = 0; k < 5; k++) begin
      cyc();
      ramstate = ACCESS;
      #1;
      chk("stv_addr", ramaddr, (k < 4) ? 32'h700 : 32'h300);
      chk("stv_dwait", 32'(dwait), (k < 4) ? 32'd0 : 32'd1);
      chk("stv_iwait", 32'(iwait), (k < 4) ? 32'd1 : 32'd0);
      cyc();
      ramstate = FREE;
      #1;
      chk("stv_idle", 32'(ramREN), 32'd0);
      chk("stv_cnt", 32'(dut.r_starve_cnt), (k < 4) ? 32'(k + 1) : 32'd0);
    end
    iREN = 1'b0;
    dREN = 1'b0;
    $display("txn starvation done");

    // Abort: data request dropped while RAM is busy
    cyc();
    dREN     = 1'b1;
    daddr    = 32'h500;
    ramstate = BUSY;
    cyc();
    chk("abt_ren_on", 32'(ramREN), 32'd1);
    dREN = 1'b0;
    #1;
    chk("abt_ren_drop", 32'(ramREN), 32'd0);
    chk("abt_dwait", 32'(dwait), 32'd1);
    cyc();
    chk("abt_idle", 32'(dut.r_state), 32'd0);
    chk("abt_dwait_idle", 32'(dwait), 32'd1);
    $display("txn abort done");

    // RAM error during instruction grant, cleared by reset
    iREN     = 1'b1;
    iaddr    = 32'h600;
    ramstate = ERROR;
    cyc();
    chk("err_iwait0", 32'(iwait), 32'd1);
    chk("err_flag0", 32'(err), 32'd0);
    cyc();
    chk("err_flag1", 32'(err), 32'd1);
    chk("err_hold_ren", 32'(ramREN), 32'd1);
    chk("err_iwait1", 32'(iwait), 32'd1);
    cyc();
    chk("err_sticky", 32'(err), 32'd1);
    nRST = 1'b0;
    #1;
    chk("err_rst_flag", 32'(err), 32'd0);
    chk("err_rst_ren", 32'(ramREN), 32'd0);
    chk("err_rst_state", 32'(dut.r_state), 32'd0);
    iREN     = 1'b0;
    ramstate = FREE;
    cyc();
    nRST = 1'b1;
    cyc();
    $display("txn error_reset done");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
